// File: rtl/aes_kat_sequencer.sv
// Known-answer self-test sequencer for an external AES encrypt/decrypt core pair.
// Encrypts PT, decrypts the captured ciphertext, and tallies pass/fail runs.
module aes_kat_sequencer #(
  parameter int            DW      = 128,
  parameter logic [DW-1:0] PT      = 128'h00112233445566778899aabbccddeeff,
  parameter logic [DW-1:0] EXP128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
  parameter logic [DW-1:0] EXP192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191,
  parameter logic [DW-1:0] EXP256  = 128'h8ea2b7ca516745bfeafc49904b496089,
  parameter int            TIMEOUT = 64,
  parameter int            CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             loop,
  input  logic [1:0]       mode,
  output logic             cip_start,
  output logic [1:0]       cip_mode,
  output logic [DW-1:0]    cip_in,
  input  logic             cip_done,
  input  logic [DW-1:0]    cip_out,
  output logic             dec_start,
  output logic [1:0]       dec_mode,
  output logic [DW-1:0]    dec_in,
  input  logic             dec_done,
  input  logic [DW-1:0]    dec_out,
  output logic             busy,
  output logic             done,
  output logic             e_ok,
  output logic             d_ok,
  output logic             timeout,
  output logic [3:0]       nr,
  output logic [DW-1:0]    result,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  typedef enum logic [2:0] {IDLE, ENC_REQ, ENC_WAIT, DEC_REQ, DEC_WAIT, CHECK, DONE} state_e;

  localparam int               TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]    WAIT_LAST = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [3:0]         nr_q, nr_d;
  logic [DW-1:0]      ct_q, ct_d;
  logic [DW-1:0]      result_q, result_d;
  logic               e_ok_q, e_ok_d, d_ok_q, d_ok_d, timeout_q, timeout_d;
  logic [TW-1:0]      wcnt_q, wcnt_d;
  logic [CNT_W-1:0]   pass_q, pass_d, fail_q, fail_d;
  logic [DW-1:0]      expSel;
  logic               abort;

  function automatic logic [3:0] nrOf(input logic [1:0] m);
    case (m)
      2'b00:   nrOf = 4'd10;
      2'b01:   nrOf = 4'd12;
      default: nrOf = 4'd14;
    endcase
  endfunction

  assign abort = (mode == 2'b11);

  always_comb begin
    case (mode_q)
      2'b00:   expSel = EXP128;
      2'b01:   expSel = EXP192;
      default: expSel = EXP256;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    nr_d      = nr_q;
    ct_d      = ct_q;
    result_d  = result_q;
    e_ok_d    = e_ok_q;
    d_ok_d    = d_ok_q;
    timeout_d = timeout_q;
    wcnt_d    = wcnt_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    // Abort wins over everything outside IDLE and leaves all tallies and flags untouched.
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            mode_d    = mode;
            nr_d      = nrOf(mode);
            e_ok_d    = 1'b0;
            d_ok_d    = 1'b0;
            timeout_d = 1'b0;
            state_d   = ENC_REQ;
          end
        end
        ENC_REQ: begin
          wcnt_d  = '0;
          state_d = ENC_WAIT;
        end
        ENC_WAIT: begin
          if (cip_done) begin
            ct_d     = cip_out;
            result_d = cip_out;
            e_ok_d   = (cip_out == expSel);
            state_d  = DEC_REQ;
          end else if (wcnt_q == WAIT_LAST) begin
            timeout_d = 1'b1;
            e_ok_d    = 1'b0;
            state_d   = CHECK;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
        DEC_REQ: begin
          wcnt_d  = '0;
          state_d = DEC_WAIT;
        end
        DEC_WAIT: begin
          if (dec_done) begin
            result_d = dec_out;
            d_ok_d   = (dec_out == PT);
            state_d  = CHECK;
          end else if (wcnt_q == WAIT_LAST) begin
            timeout_d = 1'b1;
            d_ok_d    = 1'b0;
            state_d   = CHECK;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
        CHECK: begin
          if (e_ok_q && d_ok_q) begin
            if (pass_q != CNT_MAX) pass_d = pass_q + 1'b1;
          end else begin
            if (fail_q != CNT_MAX) fail_d = fail_q + 1'b1;
          end
          state_d = DONE;
        end
        DONE: begin
          if (loop) begin
            mode_d    = mode;
            nr_d      = nrOf(mode);
            e_ok_d    = 1'b0;
            d_ok_d    = 1'b0;
            timeout_d = 1'b0;
            state_d   = ENC_REQ;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= 2'b00;
      nr_q      <= 4'd0;
      ct_q      <= '0;
      result_q  <= '0;
      e_ok_q    <= 1'b0;
      d_ok_q    <= 1'b0;
      timeout_q <= 1'b0;
      wcnt_q    <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      nr_q      <= nr_d;
      ct_q      <= ct_d;
      result_q  <= result_d;
      e_ok_q    <= e_ok_d;
      d_ok_q    <= d_ok_d;
      timeout_q <= timeout_d;
      wcnt_q    <= wcnt_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
    end
  end

  // Request and done strobes are suppressed in an aborting cycle so no core is kicked off.
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE) && !abort;
  assign cip_start = (state_q == ENC_REQ) && !abort;
  assign dec_start = (state_q == DEC_REQ) && !abort;
  assign cip_mode  = mode_q;
  assign dec_mode  = mode_q;
  assign cip_in    = PT;
  assign dec_in    = ct_q;
  assign e_ok      = e_ok_q;
  assign d_ok      = d_ok_q;
  assign timeout   = timeout_q;
  assign nr        = nr_q;
  assign result    = result_q;
  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;

endmodule
